territory_tally: RTL and testbench

TERRITORY_TALLY -- requirements
Module: territory_tally

---
 rtl/territory_tally.sv | 228 ++++++++++++++++++++++
 tb/tb_territory_tally.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/territory_tally.sv
// territory_tally: clears a colour RAM, stamps player positions on each tick,
// then sweeps the board to count cells per colour and ranks the players.

// Per-player cell counter, cleared at the start of a clear or scan sweep.
module territory_lane #(
    parameter int C_BITS = 16
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              clr,
    input  logic              inc,
    output logic [C_BITS-1:0] count
);
    // Count width covers every cell, so the increment never wraps.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)  count <= '0;
        else if (clr) count <= '0;
        else if (inc) count <= count + 1'b1;
    end
endmodule

module territory_tally #(
    parameter int NUM_PLAYERS = 4,
    parameter int X_BITS      = 8,
    parameter int Y_BITS      = 7,
    parameter int X_MAX       = 159,
    parameter int Y_MAX       = 119,
    localparam int A_BITS     = X_BITS + Y_BITS,
    localparam int C_BITS     = A_BITS + 1
) (
    input  logic                          CLOCK_50,
    input  logic                          resetn,
    input  logic                          start,
    input  logic                          running,
    input  logic                          tick,
    input  logic [NUM_PLAYERS*A_BITS-1:0] positions,
    output logic [A_BITS-1:0]             address,
    output logic                          wren,
    output logic [2:0]                    data_to_ram,
    input  logic [2:0]                    ram_output,
    output logic [NUM_PLAYERS*C_BITS-1:0] counts,
    output logic [NUM_PLAYERS*3-1:0]      ordered_colours,
    output logic                          done_ordering,
    output logic                          busy,
    output logic                          overrun
);
    typedef enum logic [2:0] {
        IDLE, CLEAR, ARMED, PLAY, WRITE, SCAN, RANK, DONE
    } state_t;

    typedef struct packed {
        logic [A_BITS-1:0] addr;
        logic              we;
        logic [2:0]        data;
    } ram_req_t;

    localparam logic [X_BITS-1:0] XL     = X_BITS'(X_MAX);
    localparam logic [Y_BITS-1:0] YL     = Y_BITS'(Y_MAX);
    localparam logic [2:0]        LAST_K = 3'(NUM_PLAYERS - 1);

    state_t                               state, state_d;
    ram_req_t                             req;
    logic [X_BITS-1:0]                    x_cnt;
    logic [Y_BITS-1:0]                    y_cnt;
    logic                                 sweep_step, sweep_last, sweep_done;
    logic [2:0]                           k;
    logic                                 scan_issue;
    logic [0:0]                           vld_pipe;
    logic [A_BITS-1:0]                    cur_pos;
    logic                                 cur_in_range;
    logic                                 clear_entry, scan_entry;
    logic [NUM_PLAYERS-1:0][C_BITS-1:0]   cnt;
    logic [NUM_PLAYERS-1:0][2:0]          ord;
    logic [NUM_PLAYERS-1:0]               picked;
    logic [2:0]                           best_idx;
    logic [C_BITS-1:0]                    best_cnt;
    logic                                 found;

    assign sweep_last   = (x_cnt == XL) && (y_cnt == YL);
    assign cur_pos      = positions[int'(k)*A_BITS +: A_BITS];
    assign cur_in_range = (cur_pos[A_BITS-1 -: X_BITS] <= XL) &&
                          (cur_pos[Y_BITS-1:0] <= YL);
    assign clear_entry  = ((state == IDLE) || (state == DONE)) && start;
    assign scan_entry   = (state == PLAY) && !running;

    // Next-state and RAM request decode; RAM port idles at zero by default.
    always_comb begin
        state_d    = state;
        req        = '0;
        sweep_step = 1'b0;
        scan_issue = 1'b0;
        case (state)
            IDLE, DONE: if (start) state_d = CLEAR;
            CLEAR: begin
                req        = '{addr: {x_cnt, y_cnt}, we: 1'b1, data: 3'd0};
                sweep_step = 1'b1;
                if (sweep_last) state_d = ARMED;
            end
            ARMED: if (running) state_d = PLAY;
            PLAY: begin
                if (!running)  state_d = SCAN;
                else if (tick) state_d = WRITE;
            end
            WRITE: begin
                // Off-board positions still use their slot but do not write.
                req = '{addr: cur_pos, we: cur_in_range, data: k + 3'd1};
                if (k == LAST_K) state_d = PLAY;
            end
            SCAN: begin
                if (!sweep_done) begin
                    req.addr   = {x_cnt, y_cnt};
                    sweep_step = 1'b1;
                    scan_issue = 1'b1;
                end else begin
                    // Final cycle only tallies the last read back.
                    state_d = RANK;
                end
            end
            RANK: if (k == LAST_K) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    assign address       = req.addr;
    assign wren          = req.we;
    assign data_to_ram   = req.data;
    assign busy          = (state == CLEAR) || (state == WRITE) ||
                           (state == SCAN)  || (state == RANK);
    assign done_ordering = (state == DONE);

    // State register.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_d;
    end

    // Board sweep counters, y inner / x outer, wrap to zero after the last cell.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (sweep_step) begin
            if (sweep_last) begin
                x_cnt <= '0;
                y_cnt <= '0;
            end else if (y_cnt == YL) begin
                x_cnt <= x_cnt + 1'b1;
                y_cnt <= '0;
            end else begin
                y_cnt <= y_cnt + 1'b1;
            end
        end
    end

    // Scan bookkeeping: all addresses issued, and read-data valid one cycle later.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sweep_done <= 1'b0;
            vld_pipe   <= '0;
        end else begin
            vld_pipe <= scan_issue;
            if (state_d != SCAN)                            sweep_done <= 1'b0;
            else if (state == SCAN && sweep_step && sweep_last) sweep_done <= 1'b1;
        end
    end

    // Slot counter shared by WRITE (player being stamped) and RANK (slot being filled).
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)                             k <= '0;
        else if (state == WRITE || state == RANK) k <= (k == LAST_K) ? 3'd0 : k + 3'd1;
        else                                     k <= '0;
    end

    genvar g;
    generate
        for (g = 0; g < NUM_PLAYERS; g++) begin : g_lane
            territory_lane #(.C_BITS(C_BITS)) u_lane (
                .CLOCK_50 (CLOCK_50),
                .resetn   (resetn),
                .clr      (clear_entry || scan_entry),
                .inc      (vld_pipe[0] && (ram_output == 3'(g + 1))),
                .count    (cnt[g])
            );
            assign counts[g*C_BITS +: C_BITS] = cnt[g];
        end
    endgenerate

    // Strongest unpicked player; strict compare in index order keeps ties on the lowest index.
    always_comb begin
        best_idx = '0;
        best_cnt = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (!picked[i] && (!found || cnt[i] > best_cnt)) begin
                found    = 1'b1;
                best_idx = 3'(i);
                best_cnt = cnt[i];
            end
        end
    end

    // Ranking: slot k (slot 0 at the MSBs) gets the colour chosen this cycle.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            ord    <= '0;
            picked <= '0;
        end else if (clear_entry) begin
            ord    <= '0;
            picked <= '0;
        end else if (state == RANK) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (k == 3'(i))        ord[NUM_PLAYERS-1-i] <= best_idx + 3'd1;
                if (best_idx == 3'(i)) picked[i]            <= 1'b1;
            end
        end else begin
            picked <= '0;
        end
    end

    assign ordered_colours = ord;

    // Sticky flag for ticks that land while positions are still being written.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)                      overrun <= 1'b0;
        else if (clear_entry)             overrun <= 1'b0;
        else if (state == WRITE && tick)  overrun <= 1'b1;
    end
endmodule

// File: tb/tb_territory_tally.sv
// Bench for territory_tally on a 4x4 board (3-bit x/y fields) with a registered-read RAM model.
module tb_territory_tally;
    localparam int NP = 4, XB = 3, YB = 3, AB = 6, CB = 7;

    logic            CLOCK_50 = 1'b0;
    logic            resetn = 1'b0, start = 1'b0, running = 1'b0, tick = 1'b0;
    logic [NP*AB-1:0] positions = '0;
    logic [AB-1:0]   address;
    logic            wren;
    logic [2:0]      data_to_ram, ram_output;
    logic [NP*CB-1:0] counts;
    logic [NP*3-1:0] ordered_colours;
    logic            done_ordering, busy, overrun;

    logic [2:0]      mem [0:63];
    logic            pk_en = 1'b0;
    logic [AB-1:0]   pk_a = '0;
    logic [2:0]      pk_d = '0;

    int total = 0, fails = 0;

    territory_tally #(.NUM_PLAYERS(NP), .X_BITS(XB), .Y_BITS(YB), .X_MAX(3), .Y_MAX(3)) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start), .running(running), .tick(tick),
        .positions(positions), .address(address), .wren(wren), .data_to_ram(data_to_ram),
        .ram_output(ram_output), .counts(counts), .ordered_colours(ordered_colours),
        .done_ordering(done_ordering), .busy(busy), .overrun(overrun));

    always #5 CLOCK_50 = ~CLOCK_50;

    // RAM model: one-cycle read latency; bench can poke cells directly.
    always @(posedge CLOCK_50) begin
        if (wren)       mem[address] <= data_to_ram;
        else if (pk_en) mem[pk_a]    <= pk_d;
        ram_output <= mem[address];
    end

    typedef struct packed {
        logic [7:1][4:0] n;     // cells to fill with each colour
        logic [11:0]     ord;   // expected ranking
    } vec_t;

    function automatic vec_t mk(input int n1, n2, n3, n4, n5, n6, n7, input logic [11:0] o);
        vec_t v;
        v.n[1] = 5'(n1); v.n[2] = 5'(n2); v.n[3] = 5'(n3); v.n[4] = 5'(n4);
        v.n[5] = 5'(n5); v.n[6] = 5'(n6); v.n[7] = 5'(n7); v.ord = o;
        return v;
    endfunction

    function automatic logic [AB-1:0] xy(input int x, input int y);
        return {3'(x), 3'(y)};
    endfunction

    function automatic logic [AB-1:0] cell_addr(input int j);
        return xy(j / 4, j % 4);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_counts(input string name, input int c0, c1, c2, c3);
        chk({name, " c0"}, 32'(counts[0*CB +: CB]), 32'(c0));
        chk({name, " c1"}, 32'(counts[1*CB +: CB]), 32'(c1));
        chk({name, " c2"}, 32'(counts[2*CB +: CB]), 32'(c2));
        chk({name, " c3"}, 32'(counts[3*CB +: CB]), 32'(c3));
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, " address"}, 32'(address), 0);
        chk({name, " wren/data"}, {28'd0, wren, data_to_ram}, 0);
        chk({name, " counts"}, 32'(counts), 0);
        chk({name, " flags"}, {16'd0, ordered_colours, done_ordering, busy, overrun, 1'b0}, 0);
    endtask

    task automatic poke(input logic [AB-1:0] a, input logic [2:0] d);
        pk_en = 1'b1; pk_a = a; pk_d = d;
        @(negedge CLOCK_50);
        pk_en = 1'b0;
    endtask

    // Pulse start and walk the 16 clear cycles.
    task automatic start_clear(input bit check);
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        for (int j = 0; j < 16; j++) begin
            if (check) begin
                chk($sformatf("clear addr %0d", j), 32'(address), 32'(cell_addr(j)));
                chk($sformatf("clear we/data %0d", j), {28'd0, wren, data_to_ram}, 32'h8);
            end
            @(negedge CLOCK_50);
        end
        chk("armed busy/wren", {30'd0, busy, wren}, 0);
    endtask

    task automatic arm();
        running = 1'b1;
        @(negedge CLOCK_50);
    endtask

    // One tick, then check the four write slots against the expected write-enable mask.
    task automatic do_tick(input logic [NP*AB-1:0] p, input logic [3:0] we_mask);
        positions = p; tick = 1'b1;
        @(negedge CLOCK_50);
        tick = 1'b0;
        for (int k = 0; k < NP; k++) begin
            chk($sformatf("write addr %0d", k), 32'(address), 32'(p[k*AB +: AB]));
            chk($sformatf("write we/data %0d", k), {28'd0, wren, data_to_ram}, {28'd0, we_mask[k], 3'(k + 1)});
            @(negedge CLOCK_50);
        end
    endtask

    // Drop running, time the busy window (17 scan + 4 rank), then expect DONE.
    task automatic finish_game(input string name);
        int n;
        running = 1'b0;
        @(negedge CLOCK_50);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge CLOCK_50);
        end
        chk({name, " busy cycles"}, 32'(n), 21);
        chk({name, " done"}, 32'(done_ordering), 1);
    endtask

    vec_t tbl [5];

    initial begin
        tbl[0] = mk(0, 0, 0, 0, 0, 0, 0, 12'b001_010_011_100);
        tbl[1] = mk(2, 4, 4, 1, 1, 1, 1, 12'b010_011_001_100);
        tbl[2] = mk(0, 0, 0, 16, 0, 0, 0, 12'b100_001_010_011);
        tbl[3] = mk(3, 5, 1, 7, 0, 0, 0, 12'b100_010_001_011);
        tbl[4] = mk(6, 0, 6, 0, 0, 0, 4, 12'b001_011_010_100);

        // Reset state, then seed the RAM with junk the clear must wipe.
        repeat (2) @(negedge CLOCK_50);
        chk_zero_outputs("reset");
        resetn = 1'b1;
        @(negedge CLOCK_50);
        poke(cell_addr(5), 3'd3);
        poke(cell_addr(15), 3'd7);

        start_clear(1'b1);
        chk("clear wiped cell5", 32'(mem[cell_addr(5)]), 0);
        chk("clear wiped cell15", 32'(mem[cell_addr(15)]), 0);

        // Diagonal game; a start pulse while armed/playing is ignored.
        arm();
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        chk("start ignored in play", 32'(busy), 0);
        do_tick({xy(3, 3), xy(2, 2), xy(1, 1), xy(0, 0)}, 4'b1111);
        finish_game("diag");
        chk_counts("diag", 1, 1, 1, 1);
        chk("diag ord", 32'(ordered_colours), 32'(12'b001_010_011_100));

        // Collision (p0,p2 same cell) and an off-board player 3.
        start_clear(1'b0);
        chk("counts zeroed by start", 32'(counts), 0);
        arm();
        do_tick({xy(5, 0), xy(1, 1), xy(2, 0), xy(1, 1)}, 4'b0111);
        chk("collision cell", 32'(mem[xy(1, 1)]), 3);
        finish_game("coll");
        chk_counts("coll", 0, 1, 1, 0);
        chk("coll ord", 32'(ordered_colours), 32'(12'b010_011_001_100));

        // Tick on the second write cycle is dropped and latches overrun.
        start_clear(1'b0);
        arm();
        positions = {xy(3, 3), xy(2, 2), xy(1, 1), xy(0, 0)};
        tick = 1'b1;
        @(negedge CLOCK_50);
        tick = 1'b0;
        @(negedge CLOCK_50);
        tick = 1'b1;
        @(negedge CLOCK_50);
        tick = 1'b0;
        chk("overrun set", 32'(overrun), 1);
        @(negedge CLOCK_50);
        chk("last write", {28'd0, wren, data_to_ram}, 32'hC);
        @(negedge CLOCK_50);
        chk("back in play", {30'd0, busy, wren}, 0);
        finish_game("ovr");
        chk("overrun held", 32'(overrun), 1);
        chk_counts("ovr", 1, 1, 1, 1);
        start_clear(1'b0);
        chk("overrun cleared", 32'(overrun), 0);

        // Asynchronous reset in the middle of a scan.
        arm();
        do_tick({xy(3, 0), xy(2, 0), xy(1, 0), xy(0, 0)}, 4'b1111);
        running = 1'b0;
        repeat (6) @(negedge CLOCK_50);
        #2 resetn = 1'b0;
        #1 chk_zero_outputs("midscan reset");
        @(negedge CLOCK_50);
        resetn = 1'b1;
        running = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        chk("no action without start", {30'd0, busy, wren}, 0);
        running = 1'b0;
        @(negedge CLOCK_50);

        // Table: preload RAM images during play, then scan and rank.
        for (int v = 0; v < 5; v++) begin
            int j;
            start_clear(1'b0);
            arm();
            j = 0;
            for (int c = 1; c <= 7; c++)
                for (int r = 0; r < int'(tbl[v].n[c]); r++) begin
                    poke(cell_addr(j), 3'(c));
                    j++;
                end
            finish_game($sformatf("vec%0d", v));
            chk_counts($sformatf("vec%0d", v), int'(tbl[v].n[1]), int'(tbl[v].n[2]),
                       int'(tbl[v].n[3]), int'(tbl[v].n[4]));
            chk($sformatf("vec%0d ord", v), 32'(ordered_colours), 32'(tbl[v].ord));
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
